// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module : fc_pkg
// Brief  : Shared state encoding and index/mask helpers for the FC tile scheduler.
// Rev    : 1.0
// ============================================================================
package fc_pkg;

  localparam int MASK_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } fc_sched_state_e;

  function automatic logic [31:0] ceil_div(input logic [31:0] a, input logic [31:0] d);
    return (a + d - 32'd1) / d;
  endfunction

  // Lane k is live when it falls inside the layer dimension.
  function automatic logic [MASK_W-1:0] mask_f(input logic [31:0] base,
                                               input logic [31:0] len,
                                               input int          lanes);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int k = 0; k < MASK_W; k++) begin
      if ((k < lanes) && ((base + 32'(k)) < len)) m[k] = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fc_acc_bank.sv
`default_nettype none
// ============================================================================
// Module : fc_acc_bank
// Brief  : LANES x WIDTH partial-sum registers with clear, load and wrap-around accumulate.
// Rev    : 1.0
// ============================================================================
module fc_acc_bank #(
  parameter int LANES = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   load,
  input  logic                   accum,
  input  logic [LANES*WIDTH-1:0] din,
  output logic [LANES*WIDTH-1:0] dout
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] acc;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc <= '0;
      end else if (clear) begin
        acc <= '0;
      end else if (load) begin
        acc <= din[i*WIDTH +: WIDTH];
      end else if (accum) begin
        acc <= acc + din[i*WIDTH +: WIDTH];
      end
    end

    assign dout[i*WIDTH +: WIDTH] = acc;
  end

endmodule
`default_nettype wire

// File: rtl/fc_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module : fc_tile_scheduler
// Brief  : Walks an out_len x in_len FC layer through an M_TILE x N_TILE tile datapath.
// Rev    : 1.0
// ============================================================================
module fc_tile_scheduler
  import fc_pkg::*;
#(
  parameter int M_TILE    = 4,
  parameter int N_TILE    = 4,
  parameter int ACC_WIDTH = 32,
  parameter int DIM_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [DIM_WIDTH-1:0]      cfg_out_len,
  input  logic [DIM_WIDTH-1:0]      cfg_in_len,
  output logic                      busy,
  output logic                      done,
  output logic                      tile_valid,
  input  logic                      tile_ready,
  output logic [DIM_WIDTH-1:0]      tile_m_base,
  output logic [DIM_WIDTH-1:0]      tile_n_base,
  output logic [N_TILE-1:0]         tile_n_mask,
  output logic                      tile_bias_en,
  input  logic                      part_valid,
  input  logic [M_TILE*ACC_WIDTH-1:0] part_vec,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [M_TILE*ACC_WIDTH-1:0] out_vec,
  output logic [M_TILE-1:0]         out_m_mask,
  output logic                      protocol_err
);

  fc_sched_state_e state, next_state;

  logic [DIM_WIDTH-1:0] out_len_q, in_len_q, nm, nn, m_idx, n_idx;
  logic start_acc, part_take, n_last, m_last, n_adv, m_adv;

  assign start_acc = (state == IDLE) && start && !abort;
  assign part_take = (state == WAIT) && part_valid && !abort;
  assign n_last    = (n_idx == nn - DIM_WIDTH'(1));
  assign m_last    = (m_idx == nm - DIM_WIDTH'(1));
  assign n_adv     = part_take && !n_last;
  assign m_adv     = (state == OUT) && out_ready && !abort && !m_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // abort overrides every transition, including a start seen in IDLE.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:  if (start)
                 next_state = ((cfg_out_len == '0) || (cfg_in_len == '0)) ? DONE : ISSUE;
        ISSUE: if (tile_ready) next_state = WAIT;
        WAIT:  if (part_valid) next_state = n_last ? OUT : ISSUE;
        OUT:   if (out_ready)  next_state = m_last ? DONE : ISSUE;
        DONE:  next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state != IDLE);
    done       = (state == DONE);
    tile_valid = (state == ISSUE);
    out_valid  = (state == OUT);
  end

  // Bases and masks advance together with the counters so request fields stay registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_len_q    <= '0;
      in_len_q     <= '0;
      nm           <= '0;
      nn           <= '0;
      m_idx        <= '0;
      n_idx        <= '0;
      tile_m_base  <= '0;
      tile_n_base  <= '0;
      tile_n_mask  <= '0;
      out_m_mask   <= '0;
      tile_bias_en <= 1'b0;
    end else if (start_acc) begin
      out_len_q    <= cfg_out_len;
      in_len_q     <= cfg_in_len;
      nm           <= DIM_WIDTH'(ceil_div(32'(cfg_out_len), 32'(M_TILE)));
      nn           <= DIM_WIDTH'(ceil_div(32'(cfg_in_len), 32'(N_TILE)));
      m_idx        <= '0;
      n_idx        <= '0;
      tile_m_base  <= '0;
      tile_n_base  <= '0;
      tile_n_mask  <= N_TILE'(mask_f(32'd0, 32'(cfg_in_len), N_TILE));
      out_m_mask   <= M_TILE'(mask_f(32'd0, 32'(cfg_out_len), M_TILE));
      tile_bias_en <= 1'b1;
    end else if (n_adv) begin
      n_idx        <= n_idx + DIM_WIDTH'(1);
      tile_n_base  <= tile_n_base + DIM_WIDTH'(N_TILE);
      tile_n_mask  <= N_TILE'(mask_f(32'(tile_n_base + DIM_WIDTH'(N_TILE)), 32'(in_len_q), N_TILE));
      tile_bias_en <= 1'b0;
    end else if (m_adv) begin
      m_idx        <= m_idx + DIM_WIDTH'(1);
      n_idx        <= '0;
      tile_m_base  <= tile_m_base + DIM_WIDTH'(M_TILE);
      tile_n_base  <= '0;
      tile_n_mask  <= N_TILE'(mask_f(32'd0, 32'(in_len_q), N_TILE));
      out_m_mask   <= M_TILE'(mask_f(32'(tile_m_base + DIM_WIDTH'(M_TILE)), 32'(out_len_q), M_TILE));
      tile_bias_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            protocol_err <= 1'b0;
    else if (start_acc)                    protocol_err <= 1'b0;
    else if (part_valid && state != WAIT)  protocol_err <= 1'b1;
  end

  fc_acc_bank #(
    .LANES (M_TILE),
    .WIDTH (ACC_WIDTH)
  ) u_acc_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start_acc),
    .load  (part_take && (n_idx == '0)),
    .accum (part_take && (n_idx != '0)),
    .din   (part_vec),
    .dout  (out_vec)
  );

endmodule
`default_nettype wire

// File: tb/tb_fc_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_fc_tile_scheduler
// Brief  : Directed self-checking bench for fc_tile_scheduler.
// Rev    : 1.0
// ============================================================================
module tb_fc_tile_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, abort, tile_ready, part_valid, out_ready;
  logic [15:0]  cfg_out_len, cfg_in_len;
  logic         busy, done, tile_valid, tile_bias_en, out_valid, protocol_err;
  logic [15:0]  tile_m_base, tile_n_base;
  logic [3:0]   tile_n_mask, out_m_mask;
  logic [127:0] part_vec, out_vec;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cnt  = 0;
  int done_cnt = 0;
  int overlap  = 0;

  always #5 clk = ~clk;

  fc_tile_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .cfg_out_len  (cfg_out_len),
    .cfg_in_len   (cfg_in_len),
    .busy         (busy),
    .done         (done),
    .tile_valid   (tile_valid),
    .tile_ready   (tile_ready),
    .tile_m_base  (tile_m_base),
    .tile_n_base  (tile_n_base),
    .tile_n_mask  (tile_n_mask),
    .tile_bias_en (tile_bias_en),
    .part_valid   (part_valid),
    .part_vec     (part_vec),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_vec      (out_vec),
    .out_m_mask   (out_m_mask),
    .protocol_err (protocol_err)
  );

  always @(posedge clk) begin
    if (tile_valid && tile_ready) req_cnt++;
    if (done) done_cnt++;
    if (tile_valid && out_valid) overlap++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_layer(input logic [15:0] o, input logic [15:0] i);
    cfg_out_len = o;
    cfg_in_len  = i;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic issue_tile(input string tag, input logic [15:0] mb, input logic [15:0] nb,
                            input logic [3:0] nmask, input logic bias);
    int k;
    for (k = 0; k < 50 && !tile_valid; k++) tick();
    check({tag, "_tv"}, 128'(tile_valid), 128'(1'b1));
    check({tag, "_base"}, {96'd0, tile_m_base, tile_n_base}, {96'd0, mb, nb});
    check({tag, "_mask_bias"}, {123'd0, tile_n_mask, tile_bias_en}, {123'd0, nmask, bias});
    tile_ready = 1'b1;
    tick();
    tile_ready = 1'b0;
  endtask

  task automatic send_part(input logic [127:0] v);
    part_valid = 1'b1;
    part_vec   = v;
    tick();
    part_valid = 1'b0;
    part_vec   = '0;
  endtask

  task automatic take_out(input string tag, input logic [127:0] v, input logic [3:0] mmask);
    int k;
    for (k = 0; k < 50 && !out_valid; k++) tick();
    check({tag, "_ov"}, 128'(out_valid), 128'(1'b1));
    check({tag, "_vec"}, out_vec, v);
    check({tag, "_mmask"}, 128'(out_m_mask), 128'(mmask));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    int k;
    for (k = 0; k < 50 && !done; k++) tick();
    check({tag, "_done"}, 128'(done), 128'(1'b1));
    tick();
    check({tag, "_idle"}, {126'd0, busy, done}, 128'd0);
  endtask

  initial begin
    int d0, r0;
    logic [127:0] held;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tile_ready = 1'b0;
    part_valid = 1'b0; out_ready = 1'b0; part_vec = '0;
    cfg_out_len = '0; cfg_in_len = '0;
    repeat (3) tick();
    check("rst_ctl", {123'd0, busy, done, tile_valid, out_valid, protocol_err}, 128'd0);
    check("rst_fields", {88'd0, tile_m_base, tile_n_base, tile_n_mask, out_m_mask}, 128'd0);
    check("rst_acc", out_vec, 128'd0);
    rst_n = 1'b1;
    tick();

    // 4x4 single tile
    start_layer(16'd4, 16'd4);
    check("t1_busy", 128'(busy), 128'(1'b1));
    issue_tile("t1_req", 16'd0, 16'd0, 4'b1111, 1'b1);
    send_part(pack4(1, 2, 3, 4));
    take_out("t1_out", pack4(1, 2, 3, 4), 4'b1111);
    expect_done("t1");

    // 4x12: three n-tiles accumulate
    start_layer(16'd4, 16'd12);
    issue_tile("t2_req0", 16'd0, 16'd0, 4'b1111, 1'b1);
    send_part(pack4(10, 10, 10, 10));
    issue_tile("t2_req1", 16'd0, 16'd4, 4'b1111, 1'b0);
    send_part(pack4(10, 10, 10, 10));
    issue_tile("t2_req2", 16'd0, 16'd8, 4'b1111, 1'b0);
    send_part(pack4(10, 10, 10, 10));
    take_out("t2_out", pack4(30, 30, 30, 30), 4'b1111);
    expect_done("t2");

    // 6x5: partial last n-tile and partial last row block
    r0 = req_cnt;
    start_layer(16'd6, 16'd5);
    issue_tile("t3_r00", 16'd0, 16'd0, 4'b1111, 1'b1);
    send_part(pack4(1, 2, 3, 4));
    issue_tile("t3_r01", 16'd0, 16'd4, 4'b0001, 1'b0);
    send_part(pack4(10, -20, 30, -40));
    take_out("t3_out0", pack4(11, -18, 33, -36), 4'b1111);
    issue_tile("t3_r10", 16'd4, 16'd0, 4'b1111, 1'b1);
    send_part(pack4(5, 5, 5, 5));
    issue_tile("t3_r11", 16'd4, 16'd4, 4'b0001, 1'b0);
    send_part(pack4(-1, -2, -3, -4));
    take_out("t3_out1", pack4(4, 3, 2, 1), 4'b0011);
    expect_done("t3");
    check("t3_reqs", 128'(req_cnt - r0), 128'd4);

    // Output backpressure holds the vector and issues nothing
    r0 = req_cnt;
    start_layer(16'd4, 16'd4);
    issue_tile("t4_req", 16'd0, 16'd0, 4'b1111, 1'b1);
    send_part(pack4(9, 8, 7, 6));
    held = out_vec;
    for (int k = 0; k < 5; k++) begin
      check("t4_hold", {out_vec, 1'b0}, {pack4(9, 8, 7, 6), tile_valid});
      check("t4_hold_ov", 128'(out_valid), 128'(1'b1));
      tick();
    end
    check("t4_stable", out_vec, held);
    take_out("t4_out", pack4(9, 8, 7, 6), 4'b1111);
    expect_done("t4");
    check("t4_reqs", 128'(req_cnt - r0), 128'd1);

    // Accumulator wraps modulo 2^32
    start_layer(16'd4, 16'd8);
    issue_tile("t5_req0", 16'd0, 16'd0, 4'b1111, 1'b1);
    send_part(pack4(32'h7FFF_FFFF, -1, 32'h8000_0000, 0));
    issue_tile("t5_req1", 16'd0, 16'd4, 4'b1111, 1'b0);
    send_part(pack4(1, 1, -1, 5));
    take_out("t5_out", pack4(32'h8000_0000, 0, 32'h7FFF_FFFF, 5), 4'b1111);
    expect_done("t5");

    // start and abort together in IDLE: abort wins
    r0 = req_cnt;
    cfg_out_len = 16'd4; cfg_in_len = 16'd4;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    check("t6_idle", {126'd0, busy, tile_valid}, 128'd0);
    check("t6_reqs", 128'(req_cnt - r0), 128'd0);

    // Abort in WAIT, then a stray partial result
    d0 = done_cnt;
    start_layer(16'd4, 16'd4);
    issue_tile("t7_req", 16'd0, 16'd0, 4'b1111, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t7_abort_idle", {125'd0, busy, tile_valid, out_valid}, 128'd0);
    send_part(pack4(7, 7, 7, 7));
    check("t7_perr", 128'(protocol_err), 128'(1'b1));
    repeat (3) tick();
    check("t7_no_done", 128'(done_cnt - d0), 128'd0);

    // Zero-length layer: straight to done, clears protocol_err, no request
    r0 = req_cnt;
    start_layer(16'd4, 16'd0);
    check("t8_perr_clr", 128'(protocol_err), 128'(1'b0));
    expect_done("t8");
    check("t8_reqs", 128'(req_cnt - r0), 128'd0);

    check("overlap", 128'(overlap), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
